fifo_ctrl: RTL and testbench



---
 rtl/fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the register-file FIFO built from the write/read
// ring-counter address chains. Issues one-cycle advance strobes, tracks occupancy
// and runs a flush (drain) sequence.
// Optional build macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
// cleared by err_clr.
module fifo_ctrl #(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic             flush,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic             wr_en,
  output logic             rd_en,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] rd_ptr
);

  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LastC  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] OneC   = CNT_W'(1);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_valid_q, rd_valid_d;

  // Status decodes from registered count/state only; no push/pop bypass.
  always_comb begin
    full  = (count_q == DepthC);
    empty = (count_q == '0);
    busy  = (state_q == StDrain);
  end

  // Strobe generation and next-state logic.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      StRun: begin
        wr_en = wr_req & ~full;
        rd_en = rd_req & ~empty;
        if (flush && !empty) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // DRAIN is only entered with count > 0 and left when the last entry goes.
        rd_en = 1'b1;
        if (count_q == OneC) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Occupancy, pointer mirrors and read-valid pipeline.
  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + OneC;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - OneC;
    end
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LastC) ? '0 : wr_ptr_q + OneC;
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LastC) ? '0 : rd_ptr_q + OneC;
    end
    // Drain reads discard data, so they never raise rd_valid.
    rd_valid_d = rd_en & (state_q == StRun);
  end

  // State registers; rst_n is shared with the address counters to keep them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign count    = count_q;
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;
  assign rd_valid = rd_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a set condition beats a same-cycle clear.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (state_q == StRun && wr_req && full) begin
      overflow_d = 1'b1;
    end
    if (state_q == StRun && rd_req && empty) begin
      underflow_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic       rd_req;
  logic       flush;
  logic       wr_en;
  logic       rd_en;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       busy;
  logic [3:0] count;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
`ifdef FIFO_ERR_FLAGS_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
`endif

  int tests;
  int fails;

  fifo_ctrl #(
    .DEPTH(15),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .flush    (flush),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr  (err_clr),
    .overflow (overflow),
    .underflow(underflow),
`endif
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .count    (count),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_wr_ptr"}, 32'(wr_ptr), 0);
    check({tag, "_rd_ptr"}, 32'(rd_ptr), 0);
  endtask

  // Pulse reset between the clock edges, leaving all requests idle.
  task automatic do_reset();
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    rst_n  = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill all 15 entries.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      wr_req = 1'b1;
      #1;
      check("fill_wr_en", 32'(wr_en), 1);
      check("fill_count", 32'(count), 32'(i));
    end
    @(negedge clk);
    #1;
    check("full_count", 32'(count), 15);
    check("full_flag", 32'(full), 1);
    check("full_wr_ptr_wrap", 32'(wr_ptr), 0);
    check("full_wr_en_blocked", 32'(wr_en), 0);
    @(negedge clk);
    #1;
    check("full_count_hold", 32'(count), 15);

    // Push+pop at full: only the pop is taken.
    rd_req = 1'b1;
    #1;
    check("fullpp_rd_en", 32'(rd_en), 1);
    check("fullpp_wr_en", 32'(wr_en), 0);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1;
    check("fullpp_count", 32'(count), 14);
    check("fullpp_rd_valid", 32'(rd_valid), 1);
    check("fullpp_rd_ptr", 32'(rd_ptr), 1);
    @(negedge clk);
    #1;
    check("fullpp_rd_valid_drop", 32'(rd_valid), 0);

    // Push+pop at empty: only the push is taken.
    do_reset();
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    check("emptypp_wr_en", 32'(wr_en), 1);
    check("emptypp_rd_en", 32'(rd_en), 0);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1;
    check("emptypp_count", 32'(count), 1);
    check("emptypp_empty", 32'(empty), 0);
    check("emptypp_rd_valid", 32'(rd_valid), 0);

    // Flush with count 0 has no effect.
    do_reset();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_empty_busy", 32'(busy), 0);

    // Six pushes, then flush while still pushing: 7 entries enter DRAIN.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_req = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_cycle_wr_en", 32'(wr_en), 1);
    check("flush_cycle_count", 32'(count), 6);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("drain_busy", 32'(busy), 1);
      check("drain_rd_en", 32'(rd_en), 1);
      check("drain_wr_en", 32'(wr_en), 0);
      check("drain_rd_valid", 32'(rd_valid), 0);
      check("drain_count", 32'(count), 32'(7 - i));
    end
    @(negedge clk);
    #1;
    check("postdrain_busy", 32'(busy), 0);
    check("postdrain_count", 32'(count), 0);
    check("postdrain_rd_ptr", 32'(rd_ptr), 7);
    check("postdrain_wr_ptr", 32'(wr_ptr), 7);
    check("postdrain_rd_valid", 32'(rd_valid), 0);
    check("postdrain_wr_en", 32'(wr_en), 1);
    wr_req = 1'b0;

    // 40 alternating push/pop cycles; both pointers wrap 14->0 once.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_req = (i % 2 == 0);
      rd_req = (i % 2 == 1);
      #1;
      check("alt_count", 32'(count), 32'(i % 2));
      check("alt_wr_en", 32'(wr_en), 32'(i % 2 == 0));
      check("alt_rd_en", 32'(rd_en), 32'(i % 2 == 1));
      check("alt_rd_valid", 32'(rd_valid), 32'(i > 0 && (i % 2 == 0)));
    end
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1;
    check("alt_final_count", 32'(count), 0);
    check("alt_final_wr_ptr", 32'(wr_ptr), 5);
    check("alt_final_rd_ptr", 32'(rd_ptr), 5);
    check("alt_final_rd_valid", 32'(rd_valid), 1);

    // Reset asserted mid-DRAIN at count 4.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_req = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    flush  = 1'b0;
    #1;
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_count", 32'(count), 4);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_drain_rst");
    @(negedge clk);
    rst_n  = 1'b1;
    wr_req = 1'b1;
    #1;
    check("resume_wr_en", 32'(wr_en), 1);
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    check("resume_count", 32'(count), 1);
    check("resume_busy", 32'(busy), 0);

`ifdef FIFO_ERR_FLAGS_EN
    do_reset();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    check("uflow_set", 32'(underflow), 1);
    check("uflow_no_oflow", 32'(overflow), 0);
    @(negedge clk);
    #1;
    check("uflow_sticky", 32'(underflow), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("uflow_cleared", 32'(underflow), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
